// File: rtl/dtlb_walker_pkg.sv
// Shared types for the DTLB page-table walker: address widths, PTE layout and walker states.
package dtlb_walker_pkg;

    localparam int unsigned VPN_W  = 20;
    localparam int unsigned PPN_W  = 20;
    localparam int unsigned PPTR_W = 20;

    typedef logic [VPN_W-1:0]  vpn_t;
    typedef logic [PPN_W-1:0]  ppn_t;
    typedef logic [PPTR_W-1:0] pptr_t;

    typedef struct packed {
        logic                valid;
        logic [30-PPN_W:0]   reserved;
        ppn_t                ppn;
    } pte_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StFill,
        StFault,
        StRetire
    } walker_state_t;

    // One 4-byte PTE per VPN; the physical address wraps at the pointer width.
    function automatic pptr_t pte_addr(input pptr_t base, input vpn_t vpn);
        return base + pptr_t'({vpn, 2'b00});
    endfunction

endpackage

// File: rtl/dtlb_walker_if.sv
// Single-outstanding PTE read port between the walker (master) and the memory arbiter (slave).
interface dtlb_walker_if;
    import dtlb_walker_pkg::*;

    logic        mem_req;
    pptr_t       mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/dtlb_walker.sv
// DTLB miss page-table walker: fetches one PTE per miss, then refills the DTLB or signals a fault.
module dtlb_walker
    import dtlb_walker_pkg::*;
#(
    parameter int unsigned PTE_VALID_BIT = 31,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  vpn_t               miss_vpn,
    input  pptr_t              ptbr,
    dtlb_walker_if.master      mem,
    output logic               write_en,
    output vpn_t               write_vpn,
    output ppn_t               write_ppn,
    output logic               fault,
    output vpn_t               fault_vpn,
    output logic               busy,
    output logic [CNT_W-1:0]   walk_cnt,
    output logic [CNT_W-1:0]   fault_cnt
);

    walker_state_t state_q, state_d;
    vpn_t          vpn_q;
    pptr_t         base_q;
    pte_t          pte;
    logic          pte_valid;
    logic          enter_fill;
    logic          enter_fault;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != '1)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    assign pte       = pte_t'(mem.mem_rdata);
    assign pte_valid = mem.mem_rdata[PTE_VALID_BIT];

    // Response is honoured only in WAIT, so a grant-cycle or post-reset rvalid is dropped.
    assign enter_fill  = (state_q == StWait) && mem.mem_rvalid && pte_valid;
    assign enter_fault = (state_q == StWait) && mem.mem_rvalid && !pte_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (miss) state_d = StReq;
            StReq:    if (mem.mem_gnt) state_d = StWait;
            StWait:   if (mem.mem_rvalid) state_d = pte_valid ? StFill : StFault;
            StFill:   state_d = StRetire;
            StFault:  state_d = StRetire;
            StRetire: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign mem.mem_req  = (state_q == StReq);
    assign mem.mem_addr = (state_q == StReq) ? pte_addr(base_q, vpn_q) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            vpn_q     <= '0;
            base_q    <= '0;
            write_en  <= 1'b0;
            write_vpn <= '0;
            write_ppn <= '0;
            fault     <= 1'b0;
            fault_vpn <= '0;
            walk_cnt  <= '0;
            fault_cnt <= '0;
        end else begin
            state_q  <= state_d;
            write_en <= enter_fill;
            fault    <= enter_fault;
            if ((state_q == StIdle) && miss) begin
                vpn_q  <= miss_vpn;
                base_q <= ptbr;
            end
            if (enter_fill) begin
                write_vpn <= vpn_q;
                write_ppn <= pte.ppn;
            end
            if (enter_fault) begin
                fault_vpn <= vpn_q;
            end
            walk_cnt  <= sat_inc(walk_cnt, enter_fill || enter_fault);
            fault_cnt <= sat_inc(fault_cnt, enter_fault);
        end
    end

endmodule

// File: tb/tb_dtlb_walker.sv
// Self-checking bench for dtlb_walker: vector table of walks plus reset, retrigger and saturation.
module tb_dtlb_walker;
    import dtlb_walker_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    typedef struct {
        pptr_t       base;
        vpn_t        vpn;
        logic [31:0] rdata;
        int          gnt_wait;
        int          rv_wait;
        pptr_t       exp_addr;
        bit          exp_fill;
    } vec_t;

    typedef struct {
        bit         is_fault;
        vpn_t       vpn;
        ppn_t       ppn;
        int         wc;
        int         fc;
    } sb_t;

    logic             clk;
    logic             rst;
    logic             miss;
    vpn_t             miss_vpn;
    pptr_t            ptbr;
    logic             write_en;
    vpn_t             write_vpn;
    ppn_t             write_ppn;
    logic             fault;
    vpn_t             fault_vpn;
    logic             busy;
    logic [CNT_W-1:0] walk_cnt;
    logic [CNT_W-1:0] fault_cnt;

    dtlb_walker_if mem_bus ();

    dtlb_walker #(
        .PTE_VALID_BIT (31),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .miss      (miss),
        .miss_vpn  (miss_vpn),
        .ptbr      (ptbr),
        .mem       (mem_bus),
        .write_en  (write_en),
        .write_vpn (write_vpn),
        .write_ppn (write_ppn),
        .fault     (fault),
        .fault_vpn (fault_vpn),
        .busy      (busy),
        .walk_cnt  (walk_cnt),
        .fault_cnt (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    int   m_walk;
    int   m_fault;
    sb_t  sb_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mem_req"},   32'(mem_bus.mem_req),  32'd0);
        chk({tag, " mem_addr"},  32'(mem_bus.mem_addr), 32'd0);
        chk({tag, " write_en"},  32'(write_en),         32'd0);
        chk({tag, " write_vpn"}, 32'(write_vpn),        32'd0);
        chk({tag, " write_ppn"}, 32'(write_ppn),        32'd0);
        chk({tag, " fault"},     32'(fault),            32'd0);
        chk({tag, " fault_vpn"}, 32'(fault_vpn),        32'd0);
        chk({tag, " busy"},      32'(busy),             32'd0);
        chk({tag, " walk_cnt"},  32'(walk_cnt),         32'd0);
        chk({tag, " fault_cnt"}, 32'(fault_cnt),        32'd0);
    endtask

    // Independent address model: integer arithmetic modulo 2^20.
    function automatic pptr_t model_addr(input pptr_t base, input vpn_t vpn);
        int unsigned s;
        s = (int'(base) + int'(vpn) * 4) % 32'h0010_0000;
        return pptr_t'(s);
    endfunction

    // Entered just after a rising edge; returns just after the edge that starts the IDLE cycle.
    task automatic run_walk(input vec_t v, input bit keep_miss);
        sb_t e;
        sb_t got;
        miss     = 1'b1;
        miss_vpn = v.vpn;
        ptbr     = v.base;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        miss_vpn = ~v.vpn;
        ptbr     = ~v.base;
        for (int k = 0; k < v.gnt_wait; k++) begin
            mem_bus.mem_gnt = 1'b0;
            @(negedge clk);
            chk("stall mem_req", 32'(mem_bus.mem_req), 32'd1);
            chk("stall mem_addr", 32'(mem_bus.mem_addr), 32'(v.exp_addr));
            @(posedge clk); #1;
            ptbr = ptbr + 20'h00111;
        end
        // rvalid alongside the grant must be taken as a grant only
        mem_bus.mem_gnt    = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = v.rdata ^ 32'h8000_0000;
        @(negedge clk);
        chk("req mem_req", 32'(mem_bus.mem_req), 32'd1);
        chk("req mem_addr", 32'(mem_bus.mem_addr), 32'(v.exp_addr));
        chk("req busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        for (int k = 0; k < v.rv_wait; k++) begin
            @(negedge clk);
            chk("wait mem_req", 32'(mem_bus.mem_req), 32'd0);
            chk("wait busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = v.rdata;
        if (v.exp_fill) m_walk = (m_walk == CNT_MAX) ? CNT_MAX : m_walk + 1;
        else begin
            m_walk  = (m_walk == CNT_MAX) ? CNT_MAX : m_walk + 1;
            m_fault = (m_fault == CNT_MAX) ? CNT_MAX : m_fault + 1;
        end
        e.is_fault = !v.exp_fill;
        e.vpn      = v.vpn;
        e.ppn      = ppn_t'(v.rdata & 32'h000F_FFFF);
        e.wc       = m_walk;
        e.fc       = m_fault;
        sb_q.push_back(e);
        @(negedge clk);
        chk("rvalid no early pulse", 32'({write_en, fault}), 32'd0);
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = $urandom;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got outcome with no expected entry");
        end else begin
            got = sb_q.pop_front();
            chk("outcome write_en", 32'(write_en), 32'(!got.is_fault));
            chk("outcome fault", 32'(fault), 32'(got.is_fault));
            if (got.is_fault) chk("fault_vpn", 32'(fault_vpn), 32'(got.vpn));
            else begin
                chk("write_vpn", 32'(write_vpn), 32'(got.vpn));
                chk("write_ppn", 32'(write_ppn), 32'(got.ppn));
            end
            chk("walk_cnt", 32'(walk_cnt), 32'(got.wc));
            chk("fault_cnt", 32'(fault_cnt), 32'(got.fc));
            chk("outcome mem_req", 32'(mem_bus.mem_req), 32'd0);
        end
        @(posedge clk); #1;
        miss = keep_miss;
        @(negedge clk);
        chk("retire busy", 32'(busy), 32'd1);
        chk("retire pulses", 32'({write_en, fault}), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t g;
        checks = 0;
        errors = 0;
        m_walk = 0;
        m_fault = 0;
        rst = 1'b0;
        miss = 1'b0;
        miss_vpn = '0;
        ptbr = '0;
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = '0;

        vecs[0] = '{20'h01000, 20'h00003, 32'h8000_0042, 0, 0, 20'h0100C, 1'b1};
        vecs[1] = '{20'h01000, 20'h00003, 32'h0000_0042, 0, 0, 20'h0100C, 1'b0};
        vecs[2] = '{20'h20000, 20'h00100, 32'h800A_BCDE, 5, 0, 20'h20400, 1'b1};
        vecs[3] = '{20'hFFFF0, 20'h00008, 32'h8000_1234, 0, 2, 20'h00010, 1'b1};
        vecs[4] = '{20'h12340, 20'hFFFFF, 32'h7FFF_FFFF, 2, 1, 20'h1233C, 1'b0};

        #3;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_walk(vecs[i], 1'b0);

        // miss held through RETIRE: the next walk must only start from IDLE
        run_walk(vecs[3], 1'b1);
        run_walk(vecs[0], 1'b0);

        // asynchronous reset while waiting for the PTE
        miss = 1'b1;
        miss_vpn = 20'h00005;
        ptbr = 20'h03000;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        miss = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midwalk");
        m_walk = 0;
        m_fault = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'h8000_0099;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("post-reset write_en", 32'(write_en), 32'd0);
        chk("post-reset busy2", 32'(busy), 32'd0);
        chk("post-reset walk_cnt", 32'(walk_cnt), 32'd0);
        @(posedge clk); #1;

        // counters saturate at all-ones
        for (int i = 0; i < 19; i++) begin
            g.base     = pptr_t'($urandom);
            g.vpn      = vpn_t'($urandom);
            g.rdata    = {(i < 2) ? 1'b1 : 1'b0, 31'($urandom)};
            g.gnt_wait = i % 3;
            g.rv_wait  = i % 2;
            g.exp_addr = model_addr(g.base, g.vpn);
            g.exp_fill = (i < 2);
            run_walk(g, 1'b0);
        end
        @(negedge clk);
        chk("sat walk_cnt", 32'(walk_cnt), 32'hF);
        chk("sat fault_cnt", 32'(fault_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtlb_walker.md
# dtlb_walker

Hardware page-table walker that services DTLB misses. On a miss it latches the faulting VPN, reads one page-table entry (PTE) from physical memory through a single-outstanding read port, and then does one of two things: refills the DTLB over its `write_en/write_vpn/write_ppn` port, or raises a page fault. It sits between the DTLB miss output and the data-memory arbiter, and holds the pipeline stalled (`busy`) for the duration of a walk.

## Interface
Parameters:
- `PTE_VALID_BIT`, default 31: bit index of the valid flag inside a 32-bit PTE.
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `miss`  in  1  DTLB miss; held high while the miss is unresolved.
- `miss_vpn`  in  vpn_t  VPN of the missing access.
- `ptbr`  in  pptr_t  page-table base (physical), sampled at walk start.
- `mem_req`  out  1  read request to memory arbiter.
- `mem_addr`  out  pptr_t  PTE physical address.
- `mem_gnt`  in  1  arbiter accepted the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  PTE data.
- `write_en`  out  1  one-cycle DTLB refill strobe.
- `write_vpn`  out  vpn_t  refill VPN.
- `write_ppn`  out  ppn_t  refill PPN (`mem_rdata[PPN_W-1:0]`).
- `fault`  out  1  one-cycle page-fault pulse (PTE invalid).
- `fault_vpn`  out  vpn_t  VPN that faulted; held until the next fault.
- `busy`  out  1  walk in progress; high in every state except IDLE.
- `walk_cnt`  out  CNT_W  completed walks, refill or fault.
- `fault_cnt`  out  CNT_W  faults.

## Operation
- FSM states: IDLE, REQ, WAIT, FILL, FAULT, RETIRE.
- IDLE: on `miss`, latch `miss_vpn` into `vpn_q` and `ptbr` into `base_q`, then go to REQ.
- REQ: `mem_req`=1 with `mem_addr` = `base_q + {vpn_q, 2'b00}`, truncated to pptr_t width (wraps modulo 2^20). Stay in REQ until `mem_gnt`, then go to WAIT. `mem_addr` is stable while `mem_req` is high.
- WAIT: go on `mem_rvalid`. If `mem_rdata[PTE_VALID_BIT]` is set, go to FILL. Otherwise go to FAULT. Data is captured in the `mem_rvalid` cycle.
- If `mem_gnt` and `mem_rvalid` are both high in the same REQ cycle, treat it as a grant only. A response is legal no earlier than the cycle after the grant.
- FILL: `write_en`=1, `write_vpn`=`vpn_q`, `write_ppn`=captured PPN. Go to RETIRE.
- FAULT: `fault`=1, `fault_vpn`<=`vpn_q`. Go to RETIRE.
- RETIRE: one cycle during which `miss` is ignored, so the stale miss from the refilled lookup cannot retrigger a walk. Go to IDLE.
- Changes to `miss`, `miss_vpn` or `ptbr` after latching have no effect on the current walk.
- Counters: `walk_cnt` increments on entry to FILL or FAULT. `fault_cnt` increments on entry to FAULT. Both saturate at all-ones.
- Reset (any time, including mid-walk): state IDLE. All outputs 0: `mem_req`, `mem_addr`, `write_en`, `write_vpn`, `write_ppn`, `fault`, `fault_vpn`, `busy`, `walk_cnt`, `fault_cnt`. An in-flight memory response arriving after reset is ignored, because `mem_rvalid` is only honoured in WAIT.

## Timing
- All outputs are registered, except `mem_req`, `mem_addr` and `busy`, which decode from the state register and `base_q`/`vpn_q`.
- Miss to request: `miss` high in cycle 0 (IDLE) → `mem_req` high in cycle 1.
- Best-case walk with a grant in cycle 1 and `mem_rvalid` in cycle 2: `write_en` in cycle 3, RETIRE in cycle 4, IDLE in cycle 5.
- A new miss is accepted in cycle 5 at the earliest.
- `write_en` and `fault` are mutually exclusive single-cycle pulses.

## Structure
- Add to `common`: `PPN_W`, `VPN_W`, and `pte_t` (packed: valid, reserved, ppn). The walker FSM state enum `walker_state_t` also goes in `common` so the DTLB-side assertions can reference it.
- No sub-module. Implement as one FSM, a small datapath (`vpn_q`, `base_q`, captured PPN) and two saturating counter instances of one local function.

## Test plan
- Refill: `ptbr`=0x01000, `miss_vpn`=0x00003, grant immediately, `mem_rdata`=0x8000_0042 → `mem_addr`=0x0100C; `write_en` pulse with VPN 0x00003 and PPN 0x42 in cycle 3; `walk_cnt`=1.
- Fault: same request, `mem_rdata`=0x0000_0042 → `fault` pulse with `fault_vpn`=0x00003; no `write_en`; `fault_cnt`=1 and `walk_cnt`=1.
- Backpressure: hold `mem_gnt`=0 for 5 cycles and change `ptbr` meanwhile → `mem_req` and `mem_addr` stay stable; the walk uses the original base.
- Wrap and retrigger: `ptbr`=0xFFFF0, `miss_vpn`=0x00008 → `mem_addr`=0x00010. Keep `miss` high through RETIRE → no second walk starts in RETIRE; a new walk starts in IDLE.
- Reset mid-walk: assert `rst` low in WAIT, release it, then pulse `mem_rvalid` → all outputs 0, state IDLE, no `write_en`.
- Saturation: force 0xFFFF walks (or use `CNT_W`=4 with 16 walks) → the counter holds at all-ones.
